// File: rtl/button_debounce_if.sv
// Button debouncer port bundle: raw button in, clean level and busy out.
interface button_debounce_if;
  logic btn_in;
  logic level_out;
  logic busy;

  modport master (
    output btn_in,
    input  level_out,
    input  busy
  );

  modport slave (
    input  btn_in,
    output level_out,
    output busy
  );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus a four-state stability FSM that turns a
// bouncy asynchronous button into a clean single-domain level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic              clk,
  input  logic              reset,
  button_debounce_if.slave  bus
);

  typedef enum logic [1:0] {
    LOW,
    RISE_WAIT,
    HIGH,
    FALL_WAIT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  logic                 sync1;
  logic                 sync_in;
  state_t               state;
  state_t               state_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync_in <= 1'b0;
    end else begin
      sync1   <= bus.btn_in;
      sync_in <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A single opposite sample in a WAIT state falls back to the
  // stable state it came from, restarting qualification.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      LOW: begin
        if (sync_in) begin
          state_n = RISE_WAIT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      RISE_WAIT: begin
        if (!sync_in) begin
          state_n = LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sync_in) begin
          state_n = FALL_WAIT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      FALL_WAIT: begin
        if (sync_in) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
    endcase
  end

  assign bus.level_out = (state == HIGH) ||
                         (state == FALL_WAIT);
  assign bus.busy      = (state == RISE_WAIT) ||
                         (state == FALL_WAIT);

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce at N=4, N=1 and N=15.
// Edge index i counts from the first edge that samples a new btn_in.
module tb_button_debounce;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  button_debounce_if if4 ();
  button_debounce_if if1 ();
  button_debounce_if if15 ();

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(8)
  ) u4 (
    .clk(clk),
    .reset(reset),
    .bus(if4.slave)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(1),
    .CNT_WIDTH(8)
  ) u1 (
    .clk(clk),
    .reset(reset),
    .bus(if1.slave)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(15),
    .CNT_WIDTH(4)
  ) u15 (
    .clk(clk),
    .reset(reset),
    .bus(if15.slave)
  );

  int total = 0;
  int bad = 0;

  // downstream level-to-pulse model: counts detect pulses of u4
  int   rises4 = 0;
  logic prev4 = 1'b0;
  always @(negedge clk) begin
    if (if4.level_out === 1'b1 && prev4 === 1'b0)
      rises4 = rises4 + 1;
    prev4 = if4.level_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp_v;
    logic [5:0] got_v;
    reset = 1'b1;
    if4.btn_in = 1'b0;
    if1.btn_in = 1'b0;
    if15.btn_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = 6'b000000;
      got_v = {if4.level_out, if4.busy,
               if1.level_out, if1.busy,
               if15.level_out, if15.busy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%b exp=%b",
                 i, got_v, exp_v);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    logic [1:0] exp_v;
    logic [1:0] got_v;
    for (int i = 0; i < 10; i++) begin
      if4.btn_in = (i < 3);
      tick();
      exp_v = {1'b0, (i >= 2 && i <= 4)};
      got_v = {if4.level_out, if4.busy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL glitch cyc=%0d got=%b exp=%b",
                 i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_press();
    logic [1:0] exp_v;
    logic [1:0] got_v;
    int r0;
    r0 = rises4;
    for (int i = 0; i < 20; i++) begin
      if4.btn_in = 1'b1;
      tick();
      exp_v = {(i >= 6), (i >= 2 && i <= 5)};
      got_v = {if4.level_out, if4.busy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL press cyc=%0d got=%b exp=%b",
                 i, got_v, exp_v);
      end
    end
    #6;
    total++;
    if (rises4 - r0 !== 1) begin
      bad++;
      $display("FAIL press_pulses got=%0d exp=1",
               rises4 - r0);
    end
  endtask

  task automatic test_release();
    logic [1:0] exp_v;
    logic [1:0] got_v;
    for (int i = 0; i < 10; i++) begin
      if4.btn_in = (i >= 2);
      tick();
      exp_v = {1'b1, (i == 2 || i == 3)};
      got_v = {if4.level_out, if4.busy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL fall_abort cyc=%0d got=%b exp=%b",
                 i, got_v, exp_v);
      end
    end
    for (int i = 0; i < 20; i++) begin
      if4.btn_in = 1'b0;
      tick();
      exp_v = {(i < 6), (i >= 2 && i <= 5)};
      got_v = {if4.level_out, if4.busy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL release cyc=%0d got=%b exp=%b",
                 i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] exp_v;
    logic [1:0] got_v;
    logic       exp_busy;
    int r0;
    r0 = rises4;
    for (int i = 0; i < 24; i++) begin
      if4.btn_in = !(i == 1 || i == 4);
      tick();
      exp_busy = (i == 2 || i == 4 || i == 5 ||
                  (i >= 7 && i <= 10));
      exp_v = {(i >= 11), exp_busy};
      got_v = {if4.level_out, if4.busy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b",
                 i, got_v, exp_v);
      end
    end
    #6;
    total++;
    if (rises4 - r0 !== 1) begin
      bad++;
      $display("FAIL bounce_pulses got=%0d exp=1",
               rises4 - r0);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_v;
    logic [1:0] got_v;
    int r0;
    r0 = rises4;
    if4.btn_in = 1'b1;
    reset = 1'b1;
    tick();
    got_v = {if4.level_out, if4.busy};
    total++;
    if (got_v !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_edge got=%b exp=00", got_v);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_v = {(i >= 6), (i >= 2 && i <= 5)};
      got_v = {if4.level_out, if4.busy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got=%b exp=%b",
                 i, got_v, exp_v);
      end
    end
    #6;
    total++;
    if (rises4 - r0 !== 1) begin
      bad++;
      $display("FAIL reset_mid_pulses got=%0d exp=1",
               rises4 - r0);
    end
  endtask

  task automatic test_sweep_n1();
    logic [1:0] exp_v;
    logic [1:0] got_v;
    logic       seen;
    for (int i = 0; i < 8; i++) begin
      if1.btn_in = 1'b1;
      tick();
      exp_v = {(i >= 3), (i == 2)};
      got_v = {if1.level_out, if1.busy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL n1_press cyc=%0d got=%b exp=%b",
                 i, got_v, exp_v);
      end
    end
    if1.btn_in = 1'b0;
    repeat (8) tick();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if1.btn_in = (i < 1);
      tick();
      seen = seen | if1.level_out;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL n1_glitch got=%b exp=0", seen);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if1.btn_in = (i < 2);
      tick();
      seen = seen | if1.level_out;
    end
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL n1_accept got=%b exp=1", seen);
    end
  endtask

  task automatic test_sweep_n15();
    logic [1:0] exp_v;
    logic [1:0] got_v;
    logic       seen;
    int         first;
    for (int i = 0; i < 24; i++) begin
      if15.btn_in = 1'b1;
      tick();
      exp_v = {(i >= 17), (i >= 2 && i <= 16)};
      got_v = {if15.level_out, if15.busy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL n15_press cyc=%0d got=%b exp=%b",
                 i, got_v, exp_v);
      end
    end
    if15.btn_in = 1'b0;
    repeat (24) tick();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if15.btn_in = (i < 15);
      tick();
      seen = seen | if15.level_out;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL n15_glitch got=%b exp=0", seen);
    end
    first = -1;
    for (int i = 0; i < 30; i++) begin
      if15.btn_in = (i < 16);
      tick();
      if (first < 0 && if15.level_out === 1'b1)
        first = i;
    end
    total++;
    if (first !== 17) begin
      bad++;
      $display("FAIL n15_accept first_high=%0d exp=17",
               first);
    end
  endtask

  initial begin
    if4.btn_in = 1'b0;
    if1.btn_in = 1'b0;
    if15.btn_in = 1'b0;
    test_reset();
    test_glitch();
    test_press();
    test_release();
    test_bounce();
    test_reset_mid();
    test_sweep_n1();
    test_sweep_n15();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
